// File: rtl/game_session_ctrl.sv
// Game-flow controller: idle/countdown/play/pause/end sequencing,
// tick gating, piezo source arbitration and combo tracking.
module game_session_ctrl #(
  parameter int PITCH_W  = 32,
  parameter int CD_SEC   = 3,
  parameter int TICK_SEC = 1000,
  parameter int BEEP_MS  = 150,
  parameter int CD_PITCH = 25000,
  parameter int PAUSE_EN = 1,
  parameter int COMBO_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tick,
  input  logic               i_start,
  input  logic               i_restart,
  input  logic               i_game_end,
  input  logic               i_judge_vld,
  input  logic [1:0]         i_judge,
  input  logic               i_intro_en,
  input  logic [PITCH_W-1:0] i_intro_pitch,
  input  logic               i_game_en,
  input  logic [PITCH_W-1:0] i_game_pitch,
  output logic [2:0]         o_state,
  output logic               o_gated_tick,
  output logic               o_siren_en,
  output logic               o_soft_rst,
  output logic [3:0]         o_cd_digit,
  output logic               o_play_en,
  output logic [PITCH_W-1:0] o_pitch,
  output logic [COMBO_W-1:0] o_combo,
  output logic [COMBO_W-1:0] o_max_combo
);

  localparam int MS_W = (TICK_SEC > 2) ? $clog2(TICK_SEC) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CD    = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_END   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [MS_W-1:0]    ms_q, ms_d;
  logic [3:0]         cd_q, cd_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [COMBO_W-1:0] max_q, max_d;
  logic               soft_q, soft_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ms_q    <= '0;
      cd_q    <= '0;
      combo_q <= '0;
      max_q   <= '0;
      soft_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      cd_q    <= cd_d;
      combo_q <= combo_d;
      max_q   <= max_d;
      soft_q  <= soft_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    cd_d    = cd_q;
    combo_d = combo_q;
    max_d   = max_q;
    soft_d  = 1'b0;

    // Judgements count in PLAY even when leaving PLAY this cycle
    if (i_judge_vld && state_q == S_PLAY) begin
      case (i_judge)
        2'd2, 2'd1: if (combo_q != '1) combo_d = combo_q + 1'b1;
        2'd0:       combo_d = '0;
        default:    combo_d = combo_q;
      endcase
    end
    if (combo_d > max_q) max_d = combo_d;

    if (i_restart && state_q != S_IDLE) begin
      state_d = S_IDLE;
      ms_d    = '0;
      cd_d    = '0;
      combo_d = '0;
      max_d   = '0;
      soft_d  = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_d = S_CD;
            cd_d    = 4'(CD_SEC);
            ms_d    = '0;
            combo_d = '0;
            max_d   = '0;
            soft_d  = 1'b1;
          end
        end
        S_CD: begin
          if (i_tick) begin
            if (ms_q == MS_W'(TICK_SEC - 1)) begin
              ms_d = '0;
              cd_d = cd_q - 4'd1;
              if (cd_q == 4'd1) state_d = S_PLAY;
            end else begin
              ms_d = ms_q + 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (i_game_end) state_d = S_END;
          else if (i_start && PAUSE_EN != 0) state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (i_start) state_d = S_PLAY;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    o_state      = state_q;
    o_gated_tick = i_tick && (state_q == S_PLAY);
    o_siren_en   = (state_q == S_IDLE) || (state_q == S_END);
    o_cd_digit   = (state_q == S_CD) ? cd_q : 4'd0;
    o_soft_rst   = soft_q;
    o_combo      = combo_q;
    o_max_combo  = max_q;
    o_play_en    = 1'b0;
    o_pitch      = '0;
    unique case (state_q)
      S_IDLE, S_END: begin
        o_play_en = i_intro_en;
        o_pitch   = i_intro_pitch;
      end
      S_CD: begin
        if (32'(ms_q) < BEEP_MS) begin
          o_play_en = 1'b1;
          o_pitch   = PITCH_W'(CD_PITCH);
        end
      end
      S_PLAY: begin
        o_play_en = i_game_en;
        o_pitch   = i_game_pitch;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed bench for game_session_ctrl: default instance plus
// short-countdown instances for combo saturation and no-pause builds.
module tb_game_session_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, start, restart, game_end, jvld;
  logic [1:0]  judge;
  logic        intro_en, game_en;
  logic [31:0] intro_pitch, game_pitch;

  logic [2:0]  st_a, st_b, st_c;
  logic        gt_a, gt_b, gt_c;
  logic        sir_a, sir_b, sir_c;
  logic        srst_a, srst_b, srst_c;
  logic [3:0]  cd_a, cd_b, cd_c;
  logic        pe_a, pe_b, pe_c;
  logic [31:0] pit_a, pit_b, pit_c;
  logic [9:0]  cmb_a, max_a, cmb_c, max_c;
  logic [1:0]  cmb_b, max_b;

  int checks = 0;
  int errors = 0;
  int cnt;

  always #5 clk = ~clk;

  game_session_ctrl dut_a (
    .clk(clk), .rst(rst), .i_tick(tick), .i_start(start),
    .i_restart(restart), .i_game_end(game_end),
    .i_judge_vld(jvld), .i_judge(judge),
    .i_intro_en(intro_en), .i_intro_pitch(intro_pitch),
    .i_game_en(game_en), .i_game_pitch(game_pitch),
    .o_state(st_a), .o_gated_tick(gt_a), .o_siren_en(sir_a),
    .o_soft_rst(srst_a), .o_cd_digit(cd_a), .o_play_en(pe_a),
    .o_pitch(pit_a), .o_combo(cmb_a), .o_max_combo(max_a)
  );

  game_session_ctrl #(
    .CD_SEC(1), .TICK_SEC(4), .BEEP_MS(2), .COMBO_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .i_tick(tick), .i_start(start),
    .i_restart(restart), .i_game_end(game_end),
    .i_judge_vld(jvld), .i_judge(judge),
    .i_intro_en(intro_en), .i_intro_pitch(intro_pitch),
    .i_game_en(game_en), .i_game_pitch(game_pitch),
    .o_state(st_b), .o_gated_tick(gt_b), .o_siren_en(sir_b),
    .o_soft_rst(srst_b), .o_cd_digit(cd_b), .o_play_en(pe_b),
    .o_pitch(pit_b), .o_combo(cmb_b), .o_max_combo(max_b)
  );

  game_session_ctrl #(
    .CD_SEC(1), .TICK_SEC(4), .BEEP_MS(2), .PAUSE_EN(0)
  ) dut_c (
    .clk(clk), .rst(rst), .i_tick(tick), .i_start(start),
    .i_restart(restart), .i_game_end(game_end),
    .i_judge_vld(jvld), .i_judge(judge),
    .i_intro_en(intro_en), .i_intro_pitch(intro_pitch),
    .i_game_en(game_en), .i_game_pitch(game_pitch),
    .o_state(st_c), .o_gated_tick(gt_c), .o_siren_en(sir_c),
    .o_soft_rst(srst_c), .o_cd_digit(cd_c), .o_play_en(pe_c),
    .o_pitch(pit_c), .o_combo(cmb_c), .o_max_combo(max_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic count_ticks(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      #2;
      if (gt_a) pulses++;
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic run_countdown();
    tick = 1'b1;
    for (int i = 1; i <= 3000; i++) begin
      cyc();
      if (i == 149)  chk("beep_on_149", pe_a, 1);
      if (i == 150)  chk("beep_off_150", pe_a, 0);
      if (i == 150)  chk("beep_pitch_off", pit_a, 0);
      if (i == 999)  chk("digit_3", cd_a, 3);
      if (i == 1000) chk("digit_2", cd_a, 2);
      if (i == 1000) chk("beep_sec2", pit_a, 25000);
      if (i == 2000) chk("digit_1", cd_a, 1);
      if (i == 2999) chk("still_cd_2999", st_a, 1);
      if (i == 3000) chk("play_3000", st_a, 2);
    end
    tick = 1'b0;
  endtask

  task automatic judge_step(input logic [1:0] j, input int ec,
                            input int em, input string tag);
    jvld = 1'b1;
    judge = j;
    cyc();
    jvld = 1'b0;
    chk({tag, "_combo"}, cmb_a, ec);
    chk({tag, "_max"}, max_a, em);
  endtask

  initial begin
    rst = 1'b1;
    {tick, start, restart, game_end, jvld} = '0;
    judge = 2'd0;
    intro_en = 1'b1;
    intro_pitch = 32'h1234;
    game_en = 1'b1;
    game_pitch = 32'h777;
    #12;
    chk("rst_state", st_a, 0);
    chk("rst_siren", sir_a, 1);
    chk("rst_play_en", pe_a, 1);
    chk("rst_pitch", pit_a, 32'h1234);
    chk("rst_cd", cd_a, 0);
    chk("rst_soft", srst_a, 0);
    chk("rst_combo", cmb_a, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // T1: start with coincident tick, tick must not count
    start = 1'b1;
    tick = 1'b1;
    cyc();
    start = 1'b0;
    tick = 1'b0;
    chk("t1_state_cd", st_a, 1);
    chk("t1_soft", srst_a, 1);
    chk("t1_digit", cd_a, 3);
    chk("t1_beep", pe_a, 1);
    chk("t1_beep_pitch", pit_a, 25000);
    chk("t1_no_siren", sir_a, 0);
    cyc();
    chk("t1_soft_end", srst_a, 0);
    run_countdown();
    chk("t1_digit_play", cd_a, 0);

    // T2: gated ticks and pause
    chk("t2_play_en", pe_a, 1);
    chk("t2_pitch", pit_a, 32'h777);
    count_ticks(5, cnt);
    chk("t2_gated5", cnt, 5);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t2_pause", st_a, 3);
    chk("t2_pause_pe", pe_a, 0);
    chk("t2_pause_pitch", pit_a, 0);
    count_ticks(5, cnt);
    chk("t2_gated0", cnt, 0);
    game_end = 1'b1;
    jvld = 1'b1;
    judge = 2'd2;
    cyc();
    game_end = 1'b0;
    jvld = 1'b0;
    chk("t2_pause_end_ign", st_a, 3);
    chk("t2_pause_judge_drop", cmb_a, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t2_resume", st_a, 2);

    // T3: combo sequence
    judge_step(2'd2, 1, 1, "j1");
    judge_step(2'd1, 2, 2, "j2");
    judge_step(2'd2, 3, 3, "j3");
    judge_step(2'd0, 0, 3, "j4");
    judge_step(2'd1, 1, 3, "j5");
    judge_step(2'd3, 1, 3, "j6_ign");

    // T4: judge counted on the PLAY->END edge, then END behaviour
    jvld = 1'b1;
    judge = 2'd2;
    game_end = 1'b1;
    cyc();
    jvld = 1'b0;
    chk("t4_end", st_a, 4);
    chk("t4_edge_combo", cmb_a, 2);
    chk("t4_siren", sir_a, 1);
    chk("t4_pitch", pit_a, 32'h1234);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t4_start_ign", st_a, 4);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    game_end = 1'b0;
    chk("t4_idle", st_a, 0);
    chk("t4_soft", srst_a, 1);
    chk("t4_combo0", cmb_a, 0);
    chk("t4_max0", max_a, 0);
    cyc();
    chk("t4_soft_1clk", srst_a, 0);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("t4_idle_restart_ign", srst_a, 0);

    // T5: restart beats start in COUNTDOWN; async reset mid-PLAY
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    restart = 1'b1;
    start = 1'b1;
    cyc();
    restart = 1'b0;
    start = 1'b0;
    chk("t5_idle", st_a, 0);
    chk("t5_soft", srst_a, 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_countdown();
    tick = 1'b1;
    #1;
    chk("t5_gated_pre", gt_a, 1);
    rst = 1'b1;
    #1;
    chk("t5_async_state", st_a, 0);
    chk("t5_async_gated", gt_a, 0);
    tick = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // T6 + saturation on the short-countdown instances
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t6_b_cd", cd_b, 1);
    tick = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    tick = 1'b0;
    chk("t6_b_play", st_b, 2);
    chk("t6_c_play", st_c, 2);
    for (int i = 1; i <= 5; i++) begin
      jvld = 1'b1;
      judge = 2'd2;
      cyc();
      jvld = 1'b0;
      chk("sat_combo", cmb_b, (i > 3) ? 3 : i);
    end
    chk("sat_max", max_b, 3);
    chk("wide_combo", cmb_c, 5);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t6_c_stay", st_c, 2);
    chk("t6_b_pause", st_b, 3);
    tick = 1'b1;
    #1;
    chk("t6_c_gated", gt_c, 1);
    chk("t6_b_gated", gt_b, 0);
    tick = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
